// File: rtl/sopc_test_ctrl.sv
// Bus-mapped test controller: pass/fail status, cycle counter, watchdog, char out.
// Lets a running program end its own simulation and stream characters.
module sopc_test_ctrl #(
    parameter logic [31:0] BASE_ADDR       = 32'h1000_0000,
    parameter logic [31:0] TIMEOUT_DEFAULT = 32'd10000,
    parameter logic [31:0] PASS_CODE       = 32'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  sel,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        hit,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [31:0] fail_code,
    output logic [31:0] cycles,
    output logic        char_valid,
    output logic [7:0]  char_data
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cycles_q;
    logic [31:0] limit_q;
    logic [31:0] fail_q;
    logic        cv_q;
    logic [7:0]  cd_q;
    logic        go_fail;

    logic        wr, rd;
    logic [1:0]  off;
    logic        status_wr, limit_wr, char_wr;
    logic        unused_bits;

    // Registers are word-wide; byte enables and byte offset carry no meaning.
    assign unused_bits = ^{sel, addr[1:0]};

    assign hit       = ce && (addr[31:4] == BASE_ADDR[31:4]);
    assign wr        = hit && we;
    assign rd        = hit && !we;
    assign off       = addr[3:2];
    assign status_wr = wr && (off == 2'd0) && (data_i != 32'd0);
    assign limit_wr  = wr && (off == 2'd2);
    assign char_wr   = wr && (off == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // A STATUS write in the same cycle as the watchdog trip takes priority.
    always_comb begin
        state_d = state_q;
        go_fail = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (status_wr) begin
                    if (data_i == PASS_CODE) begin
                        state_d = ST_PASS;
                    end else begin
                        state_d = ST_FAIL;
                        go_fail = 1'b1;
                    end
                end else if (limit_q != 32'd0 && cycles_q >= limit_q) begin
                    state_d = ST_TIMEOUT;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycles_q <= 32'd0;
            limit_q  <= TIMEOUT_DEFAULT;
            fail_q   <= 32'd0;
            cv_q     <= 1'b0;
            cd_q     <= 8'd0;
        end else begin
            if (state_q == ST_RUN && cycles_q != 32'hFFFF_FFFF) begin
                cycles_q <= cycles_q + 32'd1;
            end
            if (limit_wr) begin
                limit_q <= data_i;
            end
            if (go_fail) begin
                fail_q <= data_i;
            end
            cv_q <= char_wr;
            if (char_wr) begin
                cd_q <= data_i[7:0];
            end
        end
    end

    always_comb begin
        data_o = 32'd0;
        if (rd) begin
            unique case (off)
                2'd0: data_o = {30'd0, state_q};
                2'd1: data_o = cycles_q;
                2'd2: data_o = limit_q;
                2'd3: data_o = 32'd0;
            endcase
        end
    end

    assign done       = (state_q != ST_RUN);
    assign pass       = (state_q == ST_PASS);
    assign timeout    = (state_q == ST_TIMEOUT);
    assign fail_code  = fail_q;
    assign cycles     = cycles_q;
    assign char_valid = cv_q;
    assign char_data  = cd_q;

endmodule

// File: tb/tb_sopc_test_ctrl.sv
// Directed bench for sopc_test_ctrl: table of single-cycle bus ops
// plus hand-written pass/fail/timeout/putchar/reset sequences.
module tb_sopc_test_ctrl;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        hit;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [31:0] fail_code;
    logic [31:0] cycles;
    logic        char_valid;
    logic [7:0]  char_data;

    int total = 0;
    int bad   = 0;

    sopc_test_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .we         (we),
        .addr       (addr),
        .sel        (sel),
        .data_i     (data_i),
        .data_o     (data_o),
        .hit        (hit),
        .done       (done),
        .pass       (pass),
        .timeout    (timeout),
        .fail_code  (fail_code),
        .cycles     (cycles),
        .char_valid (char_valid),
        .char_data  (char_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ce;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        ehit;
        logic [31:0] erd;
        logic        edone;
        logic        ecv;
        logic [7:0]  ecd;
    } vec_t;

    vec_t vt[14];

    function automatic vec_t mkv(input logic c, input logic w,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input logic h, input logic [31:0] r,
                                 input logic dn, input logic cv,
                                 input logic [7:0] cd);
        vec_t v;
        v.ce = c; v.we = w; v.addr = a; v.wd = d;
        v.ehit = h; v.erd = r; v.edone = dn; v.ecv = cv; v.ecd = cd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic c, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
        ce = c; we = w; addr = a; data_i = d;
    endtask

    task automatic idle();
        bus(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        #3;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic run_to(input logic [31:0] n);
        int k;
        k = 0;
        while (cycles < n && k < 5000) begin
            tick();
            k++;
        end
        chk("run_to_cycles", cycles, n);
    endtask

    initial begin
        rst = 1'b1; sel = 4'hF;
        idle();
        #2;

        // reset state, checked while reset is held
        rst = 1'b0;
        #2;
        chk("rst_cycles", cycles, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pass", {31'd0, pass}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        chk("rst_fail_code", fail_code, 32'd0);
        chk("rst_char_valid", {31'd0, char_valid}, 32'd0);
        chk("rst_char_data", {24'd0, char_data}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (5) tick();
        chk("idle5_cycles", cycles, 32'd5);
        chk("idle5_done", {31'd0, done}, 32'd0);
        chk("idle5_data_o", data_o, 32'd0);
        chk("idle5_hit", {31'd0, hit}, 32'd0);

        // table: cycles during vector i is 5+i
        vt[0]  = mkv(1, 0, BASE + 4,   32'd0,   1, 32'd5,     0, 0, 8'h00);
        vt[1]  = mkv(1, 0, BASE + 0,   32'd0,   1, 32'd0,     0, 0, 8'h00);
        vt[2]  = mkv(1, 0, BASE + 8,   32'd0,   1, 32'd10000, 0, 0, 8'h00);
        vt[3]  = mkv(1, 1, BASE + 8,   32'd500, 1, 32'd0,     0, 0, 8'h00);
        vt[4]  = mkv(1, 0, BASE + 8,   32'd0,   1, 32'd500,   0, 0, 8'h00);
        vt[5]  = mkv(1, 0, 32'h2000_0004, 32'd0, 0, 32'd0,   0, 0, 8'h00);
        vt[6]  = mkv(0, 0, BASE + 4,   32'd0,   0, 32'd0,     0, 0, 8'h00);
        vt[7]  = mkv(1, 1, BASE + 4,   32'd123, 1, 32'd0,     0, 0, 8'h00);
        vt[8]  = mkv(1, 0, BASE + 4,   32'd0,   1, 32'd13,    0, 0, 8'h00);
        vt[9]  = mkv(1, 1, BASE + 0,   32'd0,   1, 32'd0,     0, 0, 8'h00);
        vt[10] = mkv(1, 1, BASE + 12,  32'h41,  1, 32'd0,     0, 1, 8'h41);
        vt[11] = mkv(1, 0, BASE + 12,  32'd0,   1, 32'd0,     0, 0, 8'h41);
        vt[12] = mkv(1, 1, BASE + 16,  32'd1,   0, 32'd0,     0, 0, 8'h41);
        vt[13] = mkv(1, 0, BASE + 0,   32'd0,   1, 32'd0,     0, 0, 8'h41);

        for (int i = 0; i < 14; i++) begin
            bus(vt[i].ce, vt[i].we, vt[i].addr, vt[i].wd);
            #1;
            chk($sformatf("v%0d_hit", i), {31'd0, hit}, {31'd0, vt[i].ehit});
            chk($sformatf("v%0d_data_o", i), data_o, vt[i].erd);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done", i), {31'd0, done}, {31'd0, vt[i].edone});
            chk($sformatf("v%0d_cv", i), {31'd0, char_valid}, {31'd0, vt[i].ecv});
            chk($sformatf("v%0d_cd", i), {24'd0, char_data}, {24'd0, vt[i].ecd});
        end
        idle();

        // pass at cycle 20
        do_reset();
        run_to(32'd20);
        bus(1, 1, BASE, 32'd1);
        tick();
        idle();
        chk("pass_pass", {31'd0, pass}, 32'd1);
        chk("pass_done", {31'd0, done}, 32'd1);
        chk("pass_cycles", cycles, 32'd21);
        repeat (3) tick();
        chk("pass_frozen", cycles, 32'd21);
        bus(1, 0, BASE, 32'd0);
        #1;
        chk("pass_status_rd", data_o, 32'd1);
        bus(1, 1, BASE, 32'hDEAD);
        tick();
        idle();
        chk("pass_sticky", {31'd0, pass}, 32'd1);
        chk("pass_fail_code", fail_code, 32'd0);

        // fail then attempted pass
        do_reset();
        run_to(32'd3);
        bus(1, 1, BASE, 32'hDEAD);
        tick();
        idle();
        chk("fail_done", {31'd0, done}, 32'd1);
        chk("fail_pass", {31'd0, pass}, 32'd0);
        chk("fail_code", fail_code, 32'hDEAD);
        bus(1, 0, BASE, 32'd0);
        #1;
        chk("fail_status_rd", data_o, 32'd2);
        bus(1, 1, BASE, 32'd1);
        tick();
        chk("fail_sticky_pass", {31'd0, pass}, 32'd0);
        chk("fail_sticky_code", fail_code, 32'hDEAD);
        bus(1, 1, BASE + 8, 32'd7);
        tick();
        bus(1, 0, BASE + 8, 32'd0);
        #1;
        chk("fail_limit_rd", data_o, 32'd7);
        chk("fail_cycles_frozen", cycles, 32'd4);
        idle();

        // watchdog trip at limit 50
        do_reset();
        bus(1, 1, BASE + 8, 32'd50);
        tick();
        idle();
        run_to(32'd50);
        chk("to_not_yet", {31'd0, timeout}, 32'd0);
        tick();
        chk("to_timeout", {31'd0, timeout}, 32'd1);
        chk("to_done", {31'd0, done}, 32'd1);
        chk("to_cycles", cycles, 32'd51);
        bus(1, 0, BASE, 32'd0);
        #1;
        chk("to_status_rd", data_o, 32'd3);
        idle();
        repeat (3) tick();
        chk("to_frozen", cycles, 32'd51);

        // status write beats watchdog in the same cycle
        do_reset();
        bus(1, 1, BASE + 8, 32'd50);
        tick();
        idle();
        run_to(32'd50);
        bus(1, 1, BASE, 32'd1);
        tick();
        idle();
        chk("race_pass", {31'd0, pass}, 32'd1);
        chk("race_timeout", {31'd0, timeout}, 32'd0);

        // lowering limit below cycles
        do_reset();
        run_to(32'd30);
        bus(1, 1, BASE + 8, 32'd10);
        tick();
        idle();
        chk("lower_not_yet", {31'd0, timeout}, 32'd0);
        chk("lower_cycles", cycles, 32'd31);
        tick();
        chk("lower_timeout", {31'd0, timeout}, 32'd1);
        chk("lower_frozen", cycles, 32'd32);

        // back-to-back putchar "OK"
        do_reset();
        run_to(32'd2);
        bus(1, 1, BASE + 12, 32'h4F);
        tick();
        chk("ok_cv1", {31'd0, char_valid}, 32'd1);
        chk("ok_cd1", {24'd0, char_data}, 32'h4F);
        bus(1, 1, BASE + 12, 32'h4B);
        tick();
        idle();
        chk("ok_cv2", {31'd0, char_valid}, 32'd1);
        chk("ok_cd2", {24'd0, char_data}, 32'h4B);
        tick();
        chk("ok_cv3", {31'd0, char_valid}, 32'd0);

        // asynchronous reset mid-run
        do_reset();
        run_to(32'd99);
        bus(1, 1, BASE + 12, 32'h21);
        tick();
        chk("ar_cv_before", {31'd0, char_valid}, 32'd1);
        bus(1, 0, BASE + 4, 32'd0);
        #1;
        chk("ar_rd_before", data_o, 32'd100);
        rst = 1'b0;
        #1;
        chk("ar_cycles", cycles, 32'd0);
        chk("ar_cv", {31'd0, char_valid}, 32'd0);
        chk("ar_cd", {24'd0, char_data}, 32'd0);
        chk("ar_done", {31'd0, done}, 32'd0);
        chk("ar_data_o", data_o, 32'd0);
        #1;
        rst = 1'b1;
        idle();
        repeat (3) tick();
        chk("ar_restart", cycles, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
